alu_fpga_console: RTL and testbench
===================================

Name: alu_fpga_console

Overview:
- Parametrised, sequential successor to the board-level ALU wrapper.
- Debounces the push buttons and loads operands A and B from the switches into separate registers on explicit key presses.
- Launches an ALU operation through a two-state handshake and captures the result and flags.
- Drives NDIGITS active-low seven-segment digits in one of four selectable display modes; the ALU itself is external and connected through the ports below.

Parameters:
DATA_W, 32, operand/result width; multiple of 4, ≥16
NDIGITS, 8, number of seven-segment digits driven
DEB_CYCLES, 16, consecutive stable-low cycles required to accept a key press (≥2)

Ports:
CLK  in  1  system clock; single clock domain
nRST  in  1  reset, synchronous, active-low
SW  in  18  SW[15:0] operand data; SW[16] upper-fill select; SW[17] unused; SW[3:0] also the opcode at execute
KEY  in  4  push buttons, active-low: [0] load A, [1] load B, [2] execute, [3] cycle display mode
alu_portA  out  DATA_W  operand A register
alu_portB  out  DATA_W  operand B register
alu_op  out  4  latched opcode (cast to aluop_t at the ALU)
alu_out  in  DATA_W  ALU result (combinational from alu_portA/alu_portB/alu_op)
alu_neg, alu_ovf, alu_zero  in  1 each  ALU flags
busy  out  1  high during EXEC
res_valid  out  1  high once any result has been captured since reset
hex  out  7*NDIGITS  digit i at hex[7i+6:7i], active-low segments

Behaviour:
- Reset (nRST low at a CLK edge):
  - A, B, alu_op, result, flags: all 0.
  - Display mode RESULT; FSM IDLE; busy=0, res_valid=0.
  - Debouncers cleared, with every key treated as released.
  - Reset mid-EXEC aborts the operation and captures nothing.
- Key conditioning:
  - Each key is synchronised by 2 flops, then counted.
  - A press is accepted once the synchronised level has been low for DEB_CYCLES consecutive cycles.
  - An accepted press emits one 1-cycle pulse; no further pulse until the key reads high for DEB_CYCLES cycles.
  - Holding a key yields exactly one pulse.
  - Latency from the first low sample to the pulse is 2+DEB_CYCLES cycles.
- Operand value: {fill, SW[15:0]}, where fill is all ones if SW[16]=1, else all zeros (DATA_W-16 bits).
- Pulse priority, one action per cycle: exec > loadA > loadB. Lower-priority pulses in the same cycle are dropped.
- FSM states IDLE and EXEC:
  - IDLE, exec pulse: alu_op <= SW[3:0]; go to EXEC.
  - IDLE, loadA pulse: A <= operand value. IDLE, loadB pulse: B <= operand value. Both stay in IDLE.
  - EXEC (exactly 1 cycle): result <= alu_out; flags <= {alu_neg, alu_ovf, alu_zero}; res_valid <= 1; back to IDLE.
  - All load and exec pulses arriving during EXEC are dropped.
- Operands do not change between the exec pulse and the capture, so the ALU has one full cycle to settle.
- Mode key: a pulse advances RESULT→OPA→OPB→FLAGS→RESULT, independent of FSM state, and is processed in any cycle.
- Display (combinational from registers; changes the cycle after the source register updates):
  - RESULT/OPA/OPB modes: digit i shows nibble [4i+3:4i] of the selected register, for i < DATA_W/4.
  - Digits with i ≥ DATA_W/4 are blank (7'b1111111).
  - If DATA_W/4 > NDIGITS, only the low NDIGITS nibbles are shown.
  - FLAGS mode: digit0=zero, digit1=ovf, digit2=neg (each shown as 0 or 1); digit3 shows alu_op as hex; higher digits blank.
- Hex encoding, active-low segments:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000
  - 8:0000000, 9:0010000, A:0001000, b:0000011, c:0100111, d:0100001, E:0000110, F:0001110
- Before the first capture (res_valid=0), RESULT mode displays all in-range digits as 0.

Test Plan:
- Reset, then idle: hex = eight copies of 1000000; busy=0; res_valid=0; alu_portA=alu_portB=0.
- Bounce rejection: KEY[0] low for DEB_CYCLES-1 cycles, high 1 cycle, low DEB_CYCLES+5 cycles, with SW=18'h0_1234 → exactly one load; alu_portA=32'h0000_1234 at 2+DEB_CYCLES cycles after the final low edge.
- Upper fill:
  - SW=18'h1_8000, press KEY[1] → alu_portB=32'hFFFF_8000.
  - Then SW=18'h0_0005, press KEY[0] → alu_portA=32'h0000_0005.
- Execute: A=5, B=3, SW[3:0]=ADD code, press KEY[2], stub ALU returns 32'h8 → busy high for exactly 1 cycle; result=8; res_valid=1; hex digit0=0000000, others 1000000.
- Mode cycling and collision:
  - Press KEY[3] three times → FLAGS mode; digit3 shows the opcode; digits 4-7 blank.
  - Exec and loadA pulses in the same cycle → exec only; A unchanged.
- Reset mid-EXEC: nRST low in the EXEC cycle → result and res_valid stay 0; state IDLE next cycle; a held key produces no pulse until it is released and pressed again.

Source files
------------

// File: rtl/alu_fpga_console.sv
// Board console for an external ALU: debounced keys load operands, launch one-cycle
// executions and cycle a multi-mode active-low seven-segment display.
module alu_fpga_console #(
    parameter int DATA_W     = 32,
    parameter int NDIGITS    = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [17:0]            SW,
    input  logic [3:0]             KEY,
    output logic [DATA_W-1:0]      alu_portA,
    output logic [DATA_W-1:0]      alu_portB,
    output logic [3:0]             alu_op,
    input  logic [DATA_W-1:0]      alu_out,
    input  logic                   alu_neg,
    input  logic                   alu_ovf,
    input  logic                   alu_zero,
    output logic                   busy,
    output logic                   res_valid,
    output logic [7*NDIGITS-1:0]   hex
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [0:0] {IDLE, EXEC} state_t;
    typedef enum logic [1:0] {M_RESULT, M_OPA, M_OPB, M_FLAGS} mode_t;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b0100111;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    logic [3:0]       key_p0, key_p1;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       locked;
    logic [3:0]       pulse;

    // Synchroniser and debouncer. A key leaves reset locked, so a button held
    // through reset must be seen released before it can fire again.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            key_p0 <= '1;
            key_p1 <= '1;
            locked <= '1;
            pulse  <= '0;
            for (int k = 0; k < 4; k++) cnt[k] <= '0;
        end else begin
            key_p0 <= KEY;
            key_p1 <= key_p0;
            pulse  <= '0;
            for (int k = 0; k < 4; k++) begin
                // Count only while the level opposes the current locked state.
                if (locked[k] == key_p1[k]) begin
                    if (cnt[k] == CNT_LAST) begin
                        cnt[k]    <= '0;
                        locked[k] <= ~locked[k];
                        pulse[k]  <= ~locked[k];
                    end else begin
                        cnt[k] <= cnt[k] + 1'b1;
                    end
                end else begin
                    cnt[k] <= '0;
                end
            end
        end
    end

    state_t state, state_n;
    mode_t  mode;
    logic   load_a, load_b, start, capture;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] result;
    logic [2:0]        flags;
    logic              unused_sw;

    assign unused_sw = SW[17];

    always_comb begin
        operand       = {DATA_W{SW[16]}};
        operand[15:0] = SW[15:0];
    end

    always_comb begin
        state_n = state;
        load_a  = 1'b0;
        load_b  = 1'b0;
        start   = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (pulse[2]) begin
                    start   = 1'b1;
                    state_n = EXEC;
                end else if (pulse[0]) begin
                    load_a = 1'b1;
                end else if (pulse[1]) begin
                    load_b = 1'b1;
                end
            end
            default: begin
                capture = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            mode      <= M_RESULT;
            alu_portA <= '0;
            alu_portB <= '0;
            alu_op    <= '0;
            result    <= '0;
            flags     <= '0;
            res_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (load_a)  alu_portA <= operand;
            if (load_b)  alu_portB <= operand;
            if (start)   alu_op    <= SW[3:0];
            if (capture) begin
                result    <= alu_out;
                flags     <= {alu_neg, alu_ovf, alu_zero};
                res_valid <= 1'b1;
            end
            if (pulse[3]) mode <= mode_t'(mode + 2'd1);
        end
    end

    assign busy = (state == EXEC);

    logic [DATA_W-1:0] shown;

    always_comb begin
        case (mode)
            M_RESULT: shown = res_valid ? result : '0;
            M_OPA:    shown = alu_portA;
            default:  shown = alu_portB;
        endcase
    end

    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
        logic [6:0] nib_seg;
        logic [6:0] flag_seg;
        if (i < DATA_W / 4) begin : g_nib
            assign nib_seg = seg7(shown[4*i +: 4]);
        end else begin : g_blank
            assign nib_seg = 7'b1111111;
        end
        if (i < 3) begin : g_flag
            assign flag_seg = seg7({3'b000, flags[i]});
        end else if (i == 3) begin : g_opc
            assign flag_seg = seg7(alu_op);
        end else begin : g_fblank
            assign flag_seg = 7'b1111111;
        end
        assign hex[7*i +: 7] = (mode == M_FLAGS) ? flag_seg : nib_seg;
    end

endmodule

// File: tb/tb_alu_fpga_console.sv
// Randomised bench for alu_fpga_console with a behavioural console model and a stub ALU.
module tb_alu_fpga_console;

    localparam int DATA_W = 32;
    localparam int NDIGITS = 8;
    localparam int D = 16;

    logic                 CLK = 1'b0;
    logic                 nRST;
    logic [17:0]          SW;
    logic [3:0]           KEY;
    logic [DATA_W-1:0]    alu_portA, alu_portB, alu_out;
    logic [3:0]           alu_op;
    logic                 alu_neg, alu_ovf, alu_zero;
    logic                 busy, res_valid;
    logic [7*NDIGITS-1:0] hex;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    always #5 CLK = ~CLK;

    alu_fpga_console #(.DATA_W(DATA_W), .NDIGITS(NDIGITS), .DEB_CYCLES(D)) dut (
        .CLK(CLK), .nRST(nRST), .SW(SW), .KEY(KEY),
        .alu_portA(alu_portA), .alu_portB(alu_portB), .alu_op(alu_op),
        .alu_out(alu_out), .alu_neg(alu_neg), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
        .busy(busy), .res_valid(res_valid), .hex(hex)
    );

    // Stub ALU: returns {neg, ovf, zero, result}
    function automatic logic [DATA_W+2:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                                input logic [3:0] op);
        logic [31:0] r;
        longint s;
        logic ovf;
        ovf = 1'b0;
        case (op)
            4'h1: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h2: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h5: r = a ^ b;
            default: r = ~a;
        endcase
        return {r[31], ovf, (r == 32'd0), r};
    endfunction

    logic [DATA_W+2:0] stub;
    assign stub     = alu_f(alu_portA, alu_portB, alu_op);
    assign alu_out  = stub[DATA_W-1:0];
    assign alu_zero = stub[DATA_W];
    assign alu_ovf  = stub[DATA_W+1];
    assign alu_neg  = stub[DATA_W+2];

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110};
        return tbl[n];
    endfunction

    // Behavioural model state
    logic [31:0] m_a = 0, m_b = 0, m_res = 0;
    logic [3:0]  m_op = 0;
    logic [2:0]  m_flags = 0;
    bit          m_valid = 0, m_exec = 0;
    int          m_mode = 0;
    int          lowrun [4];
    int          highrun [4];
    bit          armed [4];
    bit          pend [4];
    logic [3:0]  dly0 = '1, dly1 = '1;

    function automatic logic [31:0] opv(input logic [17:0] s);
        return {(s[16] ? 16'hFFFF : 16'h0000), s[15:0]};
    endfunction

    always @(posedge CLK) begin
        if (!nRST) begin
            m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_flags = 0;
            m_valid = 0; m_exec = 0; m_mode = 0;
            dly0 = '1; dly1 = '1;
            for (int k = 0; k < 4; k++) begin
                lowrun[k] = 0; highrun[k] = 0; armed[k] = 0; pend[k] = 0;
            end
        end else begin
            if (m_exec) begin
                {m_flags, m_res} = alu_f(m_a, m_b, m_op);
                m_valid = 1;
                m_exec = 0;
            end else if (pend[2]) begin
                m_op = SW[3:0];
                m_exec = 1;
            end else if (pend[0]) begin
                m_a = opv(SW);
            end else if (pend[1]) begin
                m_b = opv(SW);
            end
            if (pend[3]) m_mode = (m_mode + 1) % 4;
            for (int k = 0; k < 4; k++) begin
                logic lvl;
                lvl = dly1[k];
                dly1[k] = dly0[k];
                dly0[k] = KEY[k];
                pend[k] = 0;
                if (!lvl) begin lowrun[k]++; highrun[k] = 0; end
                else begin highrun[k]++; lowrun[k] = 0; end
                if (armed[k] && lowrun[k] == D) begin pend[k] = 1; armed[k] = 0; end
                else if (!armed[k] && highrun[k] == D) armed[k] = 1;
            end
        end
    end

    function automatic logic [7*NDIGITS-1:0] exp_hex();
        logic [7*NDIGITS-1:0] h;
        logic [31:0] v;
        v = (m_mode == 0) ? (m_valid ? m_res : 32'd0) : (m_mode == 1) ? m_a : m_b;
        for (int i = 0; i < NDIGITS; i++) begin
            if (m_mode == 3) begin
                if (i < 3)       h[7*i +: 7] = seg({3'b000, m_flags[i]});
                else if (i == 3) h[7*i +: 7] = seg(m_op);
                else             h[7*i +: 7] = 7'b1111111;
            end else begin
                h[7*i +: 7] = (i < DATA_W / 4) ? seg(v[4*i +: 4]) : 7'b1111111;
            end
        end
        return h;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails < 40) $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("portA", 64'(alu_portA), 64'(m_a));
            cmp("portB", 64'(alu_portB), 64'(m_b));
            cmp("op", 64'(alu_op), 64'(m_op));
            cmp("busy", 64'(busy), 64'(m_exec));
            cmp("res_valid", 64'(res_valid), 64'(m_valid));
            cmp("hex", 64'(hex), 64'(exp_hex()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press(input int k);
        KEY[k] = 1'b0;
        tick(D + 4);
        KEY[k] = 1'b1;
        tick(D + 4);
    endtask

    initial begin
        int bcnt;
        bit found;
        nRST = 1'b0; KEY = '1; SW = '0;
        tick(3);
        nRST = 1'b1;
        chk_en = 1;
        cmp("rst_hex", 64'(hex), 64'({8{7'b1000000}}));
        cmp("rst_busy", 64'(busy), 64'd0);
        cmp("rst_valid", 64'(res_valid), 64'd0);
        cmp("rst_A", 64'(alu_portA), 64'd0);
        cmp("rst_B", 64'(alu_portB), 64'd0);
        tick(D + 4);

        // bounce then a long hold; SW changes during hold must not reload
        SW = 18'h0_1234;
        KEY[0] = 1'b0; tick(D - 1);
        KEY[0] = 1'b1; tick(1);
        KEY[0] = 1'b0; tick(D + 3);
        SW = 18'h0_5555; tick(2);
        KEY[0] = 1'b1; tick(D + 4);
        cmp("bounce_A", 64'(alu_portA), 64'h0000_1234);

        SW = 18'h1_8000; press(1);
        cmp("fill_B", 64'(alu_portB), 64'hFFFF_8000);
        SW = 18'h0_0005; press(0);
        cmp("fill_A", 64'(alu_portA), 64'h0000_0005);
        SW = 18'h0_0003; press(1);

        // execute ADD (code 1): 5 + 3
        SW = 18'h0_0001;
        KEY[2] = 1'b0;
        bcnt = 0;
        for (int i = 0; i < D + 8; i++) begin tick(1); if (busy) bcnt++; end
        KEY[2] = 1'b1; tick(D + 4);
        cmp("busy_cycles", 64'(bcnt), 64'd1);
        cmp("exec_valid", 64'(res_valid), 64'd1);
        cmp("exec_hex", 64'(hex), 64'({{7{7'b1000000}}, 7'b0000000}));

        press(3); press(3); press(3);
        cmp("flags_hex", 64'(hex),
            64'({{4{7'b1111111}}, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000}));
        press(3);

        // exec and loadA collide: exec wins
        SW = 18'h0_0AB2;
        KEY[0] = 1'b0; KEY[2] = 1'b0;
        tick(D + 4);
        KEY = '1; tick(D + 4);
        cmp("collide_A", 64'(alu_portA), 64'h0000_0005);
        cmp("collide_op", 64'(alu_op), 64'h2);

        // reset during EXEC with exec key held
        SW = 18'h0_0004;
        KEY[2] = 1'b0;
        found = 0;
        for (int i = 0; i < 3 * D; i++) begin
            tick(1);
            if (busy) begin found = 1; break; end
        end
        cmp("exec_seen", 64'(found), 64'd1);
        nRST = 1'b0; tick(1); nRST = 1'b1;
        cmp("midrst_valid", 64'(res_valid), 64'd0);
        cmp("midrst_busy", 64'(busy), 64'd0);
        bcnt = 0;
        for (int i = 0; i < 3 * D; i++) begin tick(1); if (busy) bcnt++; end
        cmp("held_no_pulse", 64'(bcnt), 64'd0);
        KEY[2] = 1'b1; tick(D + 4);
        press(2);
        cmp("repress_valid", 64'(res_valid), 64'd1);

        // randomised key activity
        for (int n = 0; n < 120; n++) begin
            logic [3:0] mask;
            int dur;
            SW = 18'($urandom);
            mask = 4'($urandom_range(1, 15));
            dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D) : $urandom_range(D, D + 8);
            KEY = ~mask;
            tick(dur);
            if ($urandom_range(0, 2) == 0) SW = 18'($urandom);
            KEY = '1;
            tick($urandom_range(1, D + 6));
            if ($urandom_range(0, 30) == 0) begin
                nRST = 1'b0; tick(1); nRST = 1'b1;
            end
        end
        tick(2 * D + 8);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
